// File: rtl/miriscv_periph_bus.sv
// Data-side fabric: registered address decode, one-hot slave request, per-slave ready, error response.
// Latency: 2 cycles minimum on a hit (+1 per slave wait cycle), 1 cycle when unmapped, TIMEOUT_CYCLES+1 on timeout.
// Backpressure: one transfer in flight at a time; data_busy_o stalls the core until the data_rvalid_o pulse.
module miriscv_periph_bus #(
  parameter int                      N_SLAVES       = 3,
  parameter logic [32*N_SLAVES-1:0]  SLAVE_BASE     = {32'h80002000, 32'h80001000, 32'h00000000},
  parameter logic [32*N_SLAVES-1:0]  SLAVE_MASK     = {32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF800},
  parameter int                      TIMEOUT_CYCLES = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     data_req_i,
  input  logic                     data_we_i,
  input  logic [3:0]               data_be_i,
  input  logic [31:0]              data_addr_i,
  input  logic [31:0]              data_wdata_i,
  output logic [31:0]              data_rdata_o,
  output logic                     data_rvalid_o,
  output logic                     data_err_o,
  output logic                     data_busy_o,
  output logic [N_SLAVES-1:0]      slv_req_o,
  output logic                     slv_we_o,
  output logic [3:0]               slv_be_o,
  output logic [31:0]              slv_addr_o,
  output logic [31:0]              slv_wdata_o,
  input  logic [32*N_SLAVES-1:0]   slv_rdata_i,
  input  logic [N_SLAVES-1:0]      slv_ready_i,
  output logic [15:0]              err_cnt_o
);

  localparam int         SEL_W     = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  // The counter holds the number of WAIT cycles already spent; the last one is TIMEOUT_CYCLES-1.
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q;
  logic               we_q;
  logic [3:0]         be_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               err_q;
  logic [31:0]        rdata_q;
  logic [7:0]         tcnt_q;
  logic [15:0]        err_cnt_q;

  logic               dec_hit;
  logic [SEL_W-1:0]   dec_sel;
  logic [31:0]        dec_offset;
  logic               sel_ready;
  logic [31:0]        sel_rdata;
  logic               wait_timeout;

  // Address decode; scanning from the top down lets the lowest matching slot win.
  always_comb begin
    dec_hit    = 1'b0;
    dec_sel    = '0;
    dec_offset = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((data_addr_i & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        dec_hit    = 1'b1;
        dec_sel    = i[SEL_W-1:0];
        dec_offset = data_addr_i & ~SLAVE_MASK[32*i +: 32];
      end
    end
  end

  // Pick the ready and read data of the latched slave only; other ready lines are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q == i[SEL_W-1:0]) begin
        sel_ready = slv_ready_i[i];
        sel_rdata = slv_rdata_i[32*i +: 32];
      end
    end
  end

  assign wait_timeout = (tcnt_q == TCNT_LAST);

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; ready takes priority over the timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (data_req_i) state_d = dec_hit ? WAIT : RESP;
      WAIT:    if (sel_ready || wait_timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, timeout counter and response capture.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sel_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      tcnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (data_req_i) begin
            sel_q   <= dec_sel;
            we_q    <= data_we_i;
            be_q    <= data_be_i;
            addr_q  <= dec_offset;
            wdata_q <= data_wdata_i;
            err_q   <= ~dec_hit;
            rdata_q <= '0;
            tcnt_q  <= '0;
          end
        end
        WAIT: begin
          if (sel_ready) begin
            err_q   <= 1'b0;
            rdata_q <= we_q ? 32'd0 : sel_rdata;
          end else if (wait_timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            tcnt_q  <= tcnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating count of error responses, bumped during the response cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_q <= '0;
    end else if (state_q == RESP && err_q && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  // One-hot request to the latched slave while waiting.
  always_comb begin
    slv_req_o = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (state_q == WAIT && sel_q == i[SEL_W-1:0]) slv_req_o[i] = 1'b1;
    end
  end

  assign slv_we_o      = we_q;
  assign slv_be_o      = be_q;
  assign slv_addr_o    = addr_q;
  assign slv_wdata_o   = wdata_q;
  assign data_rvalid_o = (state_q == RESP);
  assign data_err_o    = data_rvalid_o & err_q;
  assign data_rdata_o  = data_rvalid_o ? rdata_q : 32'd0;
  assign data_busy_o   = (state_q != IDLE);
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: doc/miriscv_periph_bus.md
# miriscv_periph_bus

Parametrised data-side bus fabric between `miriscv_core` and N memory-mapped slaves (RAM, LED, HEX and future peripherals). It replaces the fixed combinational decoder and read mux with registered decoding and a per-slave ready handshake, so slaves may insert wait states. Unmapped accesses and accesses to slaves that never answer complete with an error response. A saturating counter records how many bus errors have occurred.

## Interface
- `N_SLAVES`, 3: number of slave ports, 1..16.
- `SLAVE_BASE`, {32'h80002000, 32'h80001000, 32'h00000000}: packed bases; slot i is bits [32i+31:32i].
- `SLAVE_MASK`, {32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF800}: packed decode masks, same layout as `SLAVE_BASE`.
- `TIMEOUT_CYCLES`, 15: maximum number of WAIT cycles before a timeout error, 1..255.
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset; one clock, asynchronous, active-low.
- `data_req_i`  in  1  core request; held high until `data_rvalid_o`.
- `data_we_i`  in  1  1 = write.
- `data_be_i`  in  4  byte enables.
- `data_addr_i`  in  32  byte address.
- `data_wdata_i`  in  32  write data.
- `data_rdata_o`  out  32  read data; valid with `data_rvalid_o`.
- `data_rvalid_o`  out  1  one-cycle completion pulse for reads and writes.
- `data_err_o`  out  1  error flag, qualified by `data_rvalid_o`.
- `data_busy_o`  out  1  high while a transfer is in flight (core stall).
- `slv_req_o`  out  N_SLAVES  one-hot request to the slaves.
- `slv_we_o`  out  1  latched write enable.
- `slv_be_o`  out  4  latched byte enables.
- `slv_addr_o`  out  32  latched offset within the slave: `addr & ~MASK_i`.
- `slv_wdata_o`  out  32  latched write data.
- `slv_rdata_i`  in  32*N_SLAVES  packed slave read data.
- `slv_ready_i`  in  N_SLAVES  slave completion; sampled only for the selected slave.
- `err_cnt_o`  out  16  saturating count of error responses.

## Operation
- Decode: slot i hits when `(data_addr_i & MASK_i) == BASE_i`. If several slots hit, the lowest index wins. If no slot hits, the access is unmapped.
- FSM states: IDLE, WAIT, RESP.
- IDLE, `data_req_i` = 1:
  - Latch we, be, offset, wdata and the slot index.
  - Hit: go to WAIT.
  - Unmapped: go to RESP with err = 1. No `slv_req_o` is raised.
- WAIT:
  - `slv_req_o[sel]` = 1; all other bits are 0.
  - `slv_ready_i[sel]` = 1: capture `slv_rdata_i[sel]` (reads only), set err = 0, go to RESP.
  - Timeout counter reaches `TIMEOUT_CYCLES` with no ready: err = 1, rdata = 0, go to RESP.
  - Ready on any other slave's line is ignored.
- RESP:
  - `data_rvalid_o` = 1 for exactly one cycle.
  - `data_rdata_o` = captured data on a successful read; 0 on writes and on errors.
  - If err = 1, `err_cnt_o` increments. It saturates at 16'hFFFF.
  - Next state is IDLE.
- `data_busy_o` = (state != IDLE).
- A new request is accepted only in IDLE. The core must keep `data_req_i` high through RESP and drop it in the cycle after `data_rvalid_o`.
- `data_req_i` falling while in WAIT does not abort the transfer. The transaction completes normally.
- All `slv_*` outputs are driven from latched registers and stay stable throughout WAIT.

## Timing
- Reset value of every output is 0; state = IDLE; `err_cnt_o` = 0; timeout counter = 0.
- Reset asserted mid-transfer returns to IDLE immediately. No `data_rvalid_o` is emitted for the aborted transfer.
- Cycle numbering: request accepted at cycle 0.
- Hit, slave ready in its first WAIT cycle: `slv_req_o` is high at cycle 1, `data_rvalid_o` at cycle 2. This 2-cycle latency is the minimum.
- Each extra cycle the slave delays ready adds 1 cycle of latency.
- Unmapped access: `data_rvalid_o` at cycle 1 with `data_err_o` = 1.
- Timeout: the counter is cleared on entering WAIT and increments every WAIT cycle. After `TIMEOUT_CYCLES` WAIT cycles, `slv_req_o` drops and RESP follows on the next cycle. Latency is `TIMEOUT_CYCLES` + 1.
- If ready arrives in the same cycle the counter reaches its limit, ready wins: the transfer completes with err = 0.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after RESP. Throughput is therefore one transfer per 3 cycles at best.

## Test plan
- Read at 0x00000010, slot 0 ready at first WAIT cycle, returns 0xDEADBEEF -> `data_rvalid_o` at cycle 2 with rdata 0xDEADBEEF, err 0; `slv_addr_o` = 0x010.
- Write 0x0000A5A5 with be 4'b0011 to 0x80001004, slot 1 ready after 3 WAIT cycles -> `slv_req_o` = 3'b010 for 3 cycles with wdata and be stable; `data_rvalid_o` at cycle 4 with rdata 0, err 0.
- Read at unmapped 0x80005000 -> `data_rvalid_o` at cycle 1, err 1, rdata 0, `slv_req_o` never set; `err_cnt_o` goes 0 -> 1.
- Read at slot 2 with ready tied low, `TIMEOUT_CYCLES` = 15 -> `slv_req_o[2]` high for exactly 15 cycles; rvalid at cycle 16, err 1.
- Assert `rst_n_i` low during WAIT at cycle 2 -> all outputs 0 asynchronously; no rvalid afterwards; the next request completes normally.
- Force `err_cnt_o` to 0xFFFF via 65536 unmapped accesses (or by preloading the counter in the bench) plus one more -> `err_cnt_o` holds at 0xFFFF.
